// File: rtl/neuron_dispatch_ctrl_if.sv
// Stream and neuron-side bus bundle for the neuron dispatch controller.
// slave = controller view, master = surrounding datapath/neuron view.
interface neuron_dispatch_ctrl_if #(
    parameter int WIDTH = 15
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_data;
    logic [1:0]       in_sel;
    logic [WIDTH:0]   act_x;
    logic [WIDTH:0]   act_y;
    logic [WIDTH:0]   act_z;
    logic [1:0]       act_sel;
    logic             act_rst;
    logic             act_done;
    logic [WIDTH:0]   act_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_data;
    logic             out_err;

    modport slave (
        input  in_valid, in_data, in_sel,
        input  act_done, act_result, out_ready,
        output in_ready, act_x, act_y, act_z, act_sel, act_rst,
        output out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_data, in_sel,
        output act_done, act_result, out_ready,
        input  in_ready, act_x, act_y, act_z, act_sel, act_rst,
        input  out_valid, out_data, out_err
    );
endinterface

// File: rtl/neuron_dispatch_ctrl.sv
// Issue-side controller for the CORDIC activation neuron: input FIFO,
// one-at-a-time launch/wait with timeout, and a held result stream.
module neuron_dispatch_ctrl #(
    parameter int             WIDTH      = 15,
    parameter int             FIFO_DEPTH = 4,
    parameter int             TIMEOUT    = 63,
    parameter logic [WIDTH:0] X_INIT     = 16'h04D5,
    parameter logic [WIDTH:0] Y_INIT     = 16'h0000
) (
    input  logic                clk,
    input  logic                ext_reset,
    neuron_dispatch_ctrl_if.slave bus,
    output logic                busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t          state, state_next;
    logic [WIDTH+2:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_next;
    logic            in_ready_q;
    logic            push, pop;
    logic [CW-1:0]   cnt;
    logic [WIDTH+2:0] head;

    assign push = bus.in_valid && in_ready_q;
    assign pop  = (state == IDLE) && (count != '0);
    assign head = mem[rd_ptr];

    assign bus.in_ready = in_ready_q;
    assign bus.act_x    = X_INIT;
    assign bus.act_y    = Y_INIT;
    assign busy         = (state != IDLE) || (count != '0);

    always_comb begin
        count_next = count;
        if (push && !pop) count_next = count + 1'b1;
        if (pop && !push) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_sel, bus.in_data};
    end

    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_next;
            in_ready_q <= (count_next != FULL);
        end
    end

    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.act_rst   = 1'b1;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) state_next = LAUNCH;
            end
            LAUNCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                bus.act_rst = 1'b0;
                if (bus.act_done || cnt == TMO) state_next = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
        endcase
    end

    // done takes priority over the timeout compare on the same cycle
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            bus.act_z    <= '0;
            bus.act_sel  <= '0;
            bus.out_data <= '0;
            bus.out_err  <= 1'b0;
            cnt          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        bus.act_z   <= head[WIDTH:0];
                        bus.act_sel <= head[WIDTH+2:WIDTH+1];
                    end
                end
                LAUNCH: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (bus.act_done) begin
                        bus.out_data <= bus.act_result;
                        bus.out_err  <= 1'b0;
                    end else if (cnt == TMO) begin
                        bus.out_data <= '0;
                        bus.out_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                end
            endcase
        end
    end
endmodule
